sha2_msg_schedule: RTL and testbench

Parametrised SHA-2 message schedule for SHA-256 (32-bit words, 64 rounds) and SHA-512/384 (64-bit words, 80 rounds). It accepts the 16 words of a padded message block over a valid/ready stream and emits the full schedule W0..W(ROUNDS-1) over a second valid/ready stream with backpressure. An internal round counter and FSM replace the external `sel` control of the previous generation. The block sits between the padding unit and the compression round core.

---
 rtl/sha2_msg_schedule.sv | 113 +++++++++++
 tb/tb_sha2_msg_schedule.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_msg_schedule.sv
// rtl/sha2_msg_schedule.sv - SHA-256/512 message schedule streamer; optional abort input via SHA2_MSG_SCHEDULE_ABORT_EN
module sha2_msg_schedule #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [6:0]        out_idx,
  output logic              out_last
`ifdef SHA2_MSG_SCHEDULE_ABORT_EN
  ,
  input  logic              abort
`endif
);

  localparam logic [0:0] ST_LOAD   = 1'b0;
  localparam logic [0:0] ST_EXPAND = 1'b1;

  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);
  localparam logic [6:0] LOAD_END_T = 7'd15;

  // Rotation/shift amounts of the small sigma functions for the chosen word size
  localparam int S0_A = (WORD_W == 64) ? 1  : 7;
  localparam int S0_B = (WORD_W == 64) ? 8  : 18;
  localparam int S0_S = (WORD_W == 64) ? 7  : 3;
  localparam int S1_A = (WORD_W == 64) ? 19 : 17;
  localparam int S1_B = (WORD_W == 64) ? 61 : 19;
  localparam int S1_S = (WORD_W == 64) ? 6  : 10;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    rotr = (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    sig0 = rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_S);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    sig1 = rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_S);
  endfunction

  logic [WORD_W-1:0] win [16];
  logic [6:0]        t;
  logic [0:0]        state;
  logic [WORD_W-1:0] exp_word;
  logic              xfer;
  logic              abort_i;

`ifdef SHA2_MSG_SCHEDULE_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Next expanded word from the 16-word window (win[0] oldest)
  always_comb begin
    exp_word = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
  end

  // Stream handshake: LOAD passes input straight through, EXPAND emits computed words
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = in_data;
    if (state == ST_LOAD) begin
      in_ready  = out_ready & ~abort_i;
      out_valid = in_valid & ~abort_i;
      out_data  = in_data;
    end else begin
      out_valid = ~abort_i;
      out_data  = exp_word;
    end
  end

  assign xfer     = out_valid & out_ready;
  assign out_idx  = t;
  assign out_last = (t == LAST_T);

  // Window shift, round counter and phase update on each transferred word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LOAD;
      t     <= 7'd0;
      for (int i = 0; i < 16; i++) begin
        win[i] <= '0;
      end
    end else if (abort_i) begin
      state <= ST_LOAD;
      t     <= 7'd0;
    end else if (xfer) begin
      for (int i = 0; i < 15; i++) begin
        win[i] <= win[i+1];
      end
      win[15] <= out_data;
      if (t == LAST_T) begin
        t     <= 7'd0;
        state <= ST_LOAD;
      end else begin
        t <= t + 7'd1;
        if (t == LOAD_END_T) begin
          state <= ST_EXPAND;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha2_msg_schedule.sv
// tb/tb_sha2_msg_schedule.sv - scoreboard bench for sha2_msg_schedule (SHA-256 and SHA-512 instances)
module tb_sha2_msg_schedule;

  typedef struct {
    logic [63:0] data;
    logic [6:0]  idx;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [6:0]  out_idx;
  logic        out_last;
`ifdef SHA2_MSG_SCHEDULE_ABORT_EN
  logic        abort = 1'b0;
`endif

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [63:0] in_data64 = '0;
  logic        out_valid64;
  logic        out_ready64 = 1'b1;
  logic [63:0] out_data64;
  logic [6:0]  out_idx64;
  logic        out_last64;

  exp_t sb32[$];
  exp_t sb64[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_hs_cyc = 0;
  bit   bp_mode = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] held_data = '0;
  logic [6:0]  held_idx = '0;
  logic [31:0] abc_hand [3] = '{32'h61626380, 32'h000F0000, 32'h7DA86405};

  sha2_msg_schedule #(.WORD_W(32), .ROUNDS(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
`ifdef SHA2_MSG_SCHEDULE_ABORT_EN
    , .abort(abort)
`endif
  );

  sha2_msg_schedule #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_data(in_data64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_data(out_data64),
    .out_idx(out_idx64), .out_last(out_last64)
`ifdef SHA2_MSG_SCHEDULE_ABORT_EN
    , .abort(1'b0)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer backpressure: random when bp_mode, otherwise always ready
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  function automatic logic [31:0] s0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  function automatic logic [63:0] s0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction
  function automatic logic [63:0] s1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  function automatic logic [31:0] msg32(input bit zero_blk, input int i);
    if (zero_blk) return 32'h0;
    if (i == 0) return 32'h61626380;
    if (i == 15) return 32'h00000018;
    return 32'h0;
  endfunction

  // Expected schedule pushed when a block is issued
  task automatic push32(input bit zero_blk);
    logic [31:0] w [64];
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = msg32(zero_blk, i);
      else w[i] = s1_32(w[i-2]) + w[i-7] + s0_32(w[i-15]) + w[i-16];
      if (!zero_blk && i >= 16 && i <= 18) w[i] = abc_hand[i-16];
      sb32.push_back('{data: 64'(w[i]), idx: 7'(i), last: (i == 63)});
    end
  endtask

  task automatic push64();
    logic [63:0] w [80];
    for (int i = 0; i < 80; i++) begin
      if (i < 16) w[i] = (i == 0) ? 64'h6162638000000000 : ((i == 15) ? 64'h18 : 64'h0);
      else w[i] = s1_64(w[i-2]) + w[i-7] + s0_64(w[i-15]) + w[i-16];
      if (i == 16) w[i] = 64'h6162638000000000;
      if (i == 17) w[i] = 64'h00030000000000C0;
      sb64.push_back('{data: w[i], idx: 7'(i), last: (i == 79)});
    end
  endtask

  task automatic send32(input logic [31:0] w, output int hc);
    int n;
    n = 0;
    hc = -1;
    in_valid = 1'b1;
    in_data = w;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        hc = cyc;
        break;
      end
      n++;
      if (n > 2000) begin
        timeout_fail("send32");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic feed32(input bit zero_blk, output int c0);
    int hc;
    c0 = -1;
    for (int i = 0; i < 16; i++) begin
      send32(msg32(zero_blk, i), hc);
      if (i == 0) c0 = hc;
    end
  endtask

  task automatic feed64();
    int n;
    for (int i = 0; i < 16; i++) begin
      n = 0;
      in_valid64 = 1'b1;
      in_data64 = (i == 0) ? 64'h6162638000000000 : ((i == 15) ? 64'h18 : 64'h0);
      forever begin
        @(negedge clk);
        if (in_ready64) break;
        n++;
        if (n > 2000) begin
          timeout_fail("send64");
          break;
        end
      end
      @(posedge clk);
      #1;
      in_valid64 = 1'b0;
    end
  endtask

  task automatic drain32();
    int n;
    n = 0;
    while (sb32.size() != 0 && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (sb32.size() != 0) timeout_fail("drain32");
    @(posedge clk);
    #1;
  endtask

  task automatic drain64();
    int n;
    n = 0;
    while (sb64.size() != 0 && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (sb64.size() != 0) timeout_fail("drain64");
    @(posedge clk);
    #1;
  endtask

  // Monitor for the SHA-256 instance: scoreboard pop, stall stability, input blocking
  always @(negedge clk) begin : mon32
    exp_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_hold_data", 64'(out_data), 64'(held_data));
        chk("stall_hold_idx", 64'(out_idx), 64'(held_idx));
      end
      if (!out_ready) chk("no_input_while_stalled", 64'(in_ready), 64'(0));
      if (out_idx >= 7'd16) chk("in_ready_low_in_expand", 64'(in_ready), 64'(0));
      if (out_valid && out_ready) begin
        if (sb32.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output32: idx %0d data %h, required no output", out_idx, out_data);
        end else begin
          e = sb32.pop_front();
          chk("w32_data", 64'(out_data), e.data);
          chk("w32_idx", 64'(out_idx), 64'(e.idx));
          chk("w32_last", 64'(out_last), 64'(e.last));
        end
        last_hs_cyc = cyc;
      end
      stall_prev = out_valid && !out_ready;
      held_data = out_data;
      held_idx = out_idx;
    end
  end

  // Monitor for the SHA-512 instance
  always @(negedge clk) begin : mon64
    exp_t e;
    if (!rst && out_valid64 && out_ready64) begin
      if (sb64.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output64: idx %0d data %h, required no output", out_idx64, out_data64);
      end else begin
        e = sb64.pop_front();
        chk("w64_data", out_data64, e.data);
        chk("w64_idx", 64'(out_idx64), 64'(e.idx));
        chk("w64_last", 64'(out_last64), 64'(e.last));
      end
    end
  end

  initial begin : stim
    int c0;
    int c1;
    int n;
    // Reset state and combinational pass-through while reset is held
    #2;
    in_valid = 1'b1;
    in_data = 32'hA5A55A5A;
    #1;
    chk("rst_out_idx", 64'(out_idx), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(1));
    chk("rst_out_data", 64'(out_data), 64'h00000000A5A55A5A);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // SHA-256 "abc", full throughput
    push32(1'b0);
    feed32(1'b0, c0);
    drain32();
    @(negedge clk);
    chk("in_ready_after_last", 64'(in_ready), 64'(1));
    chk("idx_after_last", 64'(out_idx), 64'(0));
    @(posedge clk);
    #1;

    // Same block under random backpressure
    bp_mode = 1'b1;
    push32(1'b0);
    feed32(1'b0, c0);
    drain32();
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset at round 30, then a clean block
    push32(1'b0);
    feed32(1'b0, c0);
    n = 0;
    while (out_idx != 7'd30 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (out_idx != 7'd30) timeout_fail("wait_idx30");
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_idx", 64'(out_idx), 64'(0));
    chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    sb32.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push32(1'b0);
    feed32(1'b0, c0);
    drain32();

    // Back-to-back "abc" then all-zero block, no idle cycle between them
    push32(1'b0);
    push32(1'b1);
    feed32(1'b0, c0);
    feed32(1'b1, c1);
    drain32();
    chk("b2b_cycles", 64'(last_hs_cyc - c0 + 1), 64'(128));

`ifdef SHA2_MSG_SCHEDULE_ABORT_EN
    // Abort at round 20 with the consumer ready
    push32(1'b0);
    feed32(1'b0, c0);
    n = 0;
    while (out_idx != 7'd20 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (out_idx != 7'd20) timeout_fail("wait_idx20");
    abort = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    abort = 1'b0;
    #1;
    chk("abort_idx", 64'(out_idx), 64'(0));
    chk("abort_in_ready_follows", 64'(in_ready), 64'(out_ready));
    sb32.delete();
`endif

    // SHA-512 "abc"
    push64();
    feed64();
    drain64();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
